// File: rtl/imem_fetch_responder.sv
// Instruction memory responder: fixed-latency read pipe feeding a response FIFO.
// Define IMEM_WRITE_PORT_EN to add the wr_en/wr_addr/wr_data program-load port.
module imem_fetch_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter int    BUF_DEPTH = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err
`ifdef IMEM_WRITE_PORT_EN
  ,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          pop;
  logic          push;
  logic          req_bad;
  logic [CW-1:0] credit;

  assign req_bad   = (req_addr[1:0] != 2'b00) ||
                     (req_addr[31:AW+2] != '0);
  assign req_ready = reset && (credit < CW'(BUF_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Credit covers pipeline plus buffer, so the FIFO can never overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit <= '0;
    end else begin
      credit <= credit + CW'(accept) - CW'(pop);
    end
  end

  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pe;
  logic [31:0]        pd [LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= accept;
      if (accept) begin
        pe[0] <= req_bad;
        pd[0] <= req_bad ? 32'h0 : mem[req_addr[AW+1:2]];
      end
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign push = pv[LATENCY-1];

`ifdef IMEM_WRITE_PORT_EN
  logic wr_ok;
  assign wr_ok = wr_en && (wr_addr[1:0] == 2'b00) &&
                 (wr_addr[31:AW+2] == '0);

  // Non-blocking write: a same-edge fetch of this word sees the old data.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[AW+1:2]] <= wr_data;
  end
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]          bi [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] be;
  logic [PW-1:0]        wp;
  logic [PW-1:0]        rp;
  logic [CW-1:0]        cnt;
  logic [31:0]          last_i;
  logic                 last_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      be     <= '0;
      last_i <= '0;
      last_e <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) bi[i] <= '0;
    end else begin
      if (push) begin
        bi[wp] <= pd[LATENCY-1];
        be[wp] <= pe[LATENCY-1];
        wp     <= nxt(wp);
      end
      if (pop) begin
        rp     <= nxt(rp);
        last_i <= bi[rp];
        last_e <= be[rp];
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Empty buffer shows the most recently consumed response.
  assign rsp_valid = (cnt != '0);
  assign rsp_instr = rsp_valid ? bi[rp] : last_i;
  assign rsp_err   = rsp_valid ? be[rp] : last_e;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (LATENCY=2, BUF_DEPTH=4).
// Image: word0=20020001, word1=20030002, word k=C0DE000k otherwise.
module tb_imem_fetch_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
`ifdef IMEM_WRITE_PORT_EN
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
`endif

  imem_fetch_responder #(
    .DEPTH(1024),
    .LATENCY(2),
    .BUF_DEPTH(4),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_err(rsp_err)
`ifdef IMEM_WRITE_PORT_EN
    ,
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  logic [31:0] rx_i [$];
  logic        rx_e [$];
  logic [31:0] ex_i [$];
  logic        ex_e [$];

  function automatic logic [31:0] img(input int k);
    if (k == 0) return 32'h2002_0001;
    if (k == 1) return 32'h2003_0002;
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    if (rsp_valid && rsp_ready) begin
      rx_i.push_back(rsp_instr);
      rx_e.push_back(rsp_err);
    end
    if (req_valid && req_ready) n_acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rx_i.delete();
    rx_e.delete();
    ex_i.delete();
    ex_e.delete();
    n_acc = 0;
  endtask

  task automatic expect_rsp(input logic [31:0] i, input logic e);
    ex_i.push_back(i);
    ex_e.push_back(e);
  endtask

  task automatic drain(input string tag, input int n);
    int budget;
    rsp_ready = 1'b1;
    budget = 0;
    while (rx_i.size() < n && budget < 30) begin
      cyc();
      budget++;
    end
    chk({tag, "_count"}, 32'(rx_i.size()), 32'(n));
    for (int i = 0; i < ex_i.size(); i++) begin
      if (i < rx_i.size()) begin
        chk($sformatf("%s_instr%0d", tag, i), rx_i[i], ex_i[i]);
        chk($sformatf("%s_err%0d", tag, i),
            {31'b0, rx_e[i]}, {31'b0, ex_e[i]});
      end
    end
  endtask

  initial begin
    logic acc;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
`ifdef IMEM_WRITE_PORT_EN
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`else
    for (int k = 0; k < 16; k++) dut.mem[k] = img(k);
`endif
    repeat (3) cyc();
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_instr", rsp_instr, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_req_ready", {31'b0, req_ready}, 32'h1);
`ifdef IMEM_WRITE_PORT_EN
    for (int k = 0; k < 16; k++) begin
      wr_en   = 1'b1;
      wr_addr = 32'(k * 4);
      wr_data = img(k);
      cyc();
    end
    wr_en = 1'b0;
`endif

    // 1: back-to-back fetch, latency and hold-after-empty
    clr();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    cyc();
    req_addr  = 32'h4;
    cyc();
    req_valid = 1'b0;
    chk("t1_early", {31'b0, rsp_valid}, 32'h0);
    cyc();
    chk("t1_valid0", {31'b0, rsp_valid}, 32'h1);
    chk("t1_instr0", rsp_instr, 32'h2002_0001);
    chk("t1_err0", {31'b0, rsp_err}, 32'h0);
    cyc();
    chk("t1_valid1", {31'b0, rsp_valid}, 32'h1);
    chk("t1_instr1", rsp_instr, 32'h2003_0002);
    cyc();
    chk("t1_empty", {31'b0, rsp_valid}, 32'h0);
    chk("t1_hold", rsp_instr, 32'h2003_0002);

    // 2: backpressure caps accepts at buffer depth
    clr();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    for (int c = 0; c < 10; c++) begin
      acc = req_ready;
      cyc();
      if (acc) req_addr = req_addr + 32'h4;
    end
    chk("t2_accepts", 32'(n_acc), 32'd4);
    chk("t2_ready_low", {31'b0, req_ready}, 32'h0);
    chk("t2_hold_valid", {31'b0, rsp_valid}, 32'h1);
    chk("t2_hold_instr", rsp_instr, img(2));
    req_valid = 1'b0;
    for (int k = 2; k < 6; k++) expect_rsp(img(k), 1'b0);
    drain("t2", 4);
    chk("t2_resume", {31'b0, req_ready}, 32'h1);

    // 3: misaligned and out-of-range, order kept
    clr();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h2;
    cyc();
    req_addr  = 32'h1000;
    cyc();
    req_addr  = 32'h0;
    cyc();
    req_valid = 1'b0;
    expect_rsp(32'h0, 1'b1);
    expect_rsp(32'h0, 1'b1);
    expect_rsp(32'h2002_0001, 1'b0);
    drain("t3", 3);

    // 4: full credit, then streaming pop + accept together
    clr();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = 32'(k * 4);
      cyc();
    end
    req_valid = 1'b0;
    repeat (3) cyc();
    chk("t4_full", {31'b0, req_ready}, 32'h0);
    n_acc     = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    for (int c = 0; c < 6; c++) begin
      acc = req_ready;
      cyc();
      if (acc) req_addr = req_addr + 32'h4;
      if (c > 0) chk($sformatf("t4_ready%0d", c),
                     {31'b0, req_ready}, 32'h1);
    end
    req_valid = 1'b0;
    chk("t4_accepts", 32'(n_acc), 32'd5);
    for (int k = 0; k < 9; k++) expect_rsp(img(k), 1'b0);
    drain("t4", 9);

    // 5: reset with outstanding requests
    clr();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = 32'(k * 4);
      cyc();
    end
    req_valid = 1'b0;
    repeat (3) cyc();
    chk("t5_pre_valid", {31'b0, rsp_valid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("t5_rst_ready", {31'b0, req_ready}, 32'h0);
    chk("t5_rst_instr", rsp_instr, 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) cyc();
    chk("t5_no_stale", 32'(rx_i.size()), 32'd0);
    req_valid = 1'b1;
    req_addr  = 32'h4;
    cyc();
    req_valid = 1'b0;
    expect_rsp(32'h2003_0002, 1'b0);
    drain("t5", 1);

`ifdef IMEM_WRITE_PORT_EN
    // 6: write/read collision returns old word; bad writes ignored
    clr();
    rsp_ready = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 32'h8;
    wr_data   = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    cyc();
    wr_addr   = 32'hD;
    wr_data   = 32'h1111_1111;
    cyc();
    wr_addr   = 32'h1004;
    wr_data   = 32'h2222_2222;
    req_addr  = 32'hC;
    cyc();
    wr_en     = 1'b0;
    req_addr  = 32'h4;
    cyc();
    req_valid = 1'b0;
    expect_rsp(img(2), 1'b0);
    expect_rsp(32'hDEAD_BEEF, 1'b0);
    expect_rsp(img(3), 1'b0);
    expect_rsp(img(1), 1'b0);
    drain("t6", 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
